uart_bus_master: RTL and testbench

//  Bus initiator for the UART memory-mapped register pair (DATA at offset 0x00,

---
 rtl/uart_bus_master.sv | 131 +++++++++++++
 tb/tb_uart_bus_master.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_bus_master.sv
// Polled bus initiator for a UART DATA/STATUS register pair: drains a TX byte FIFO into DATA
// and forwards bytes read from DATA on a valid/ready port. Stats: UART_BUS_MASTER_STATS_EN.
`timescale 1ns / 1ps

module uart_bus_master #(
  parameter int unsigned FIFO_AW    = 2,
  parameter int unsigned POLL_GAP   = 0,
  parameter int unsigned WR_HOLDOFF = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_tx_valid,
  input  logic [7:0]  s_tx_data,
  output logic        s_tx_ready,
  output logic        m_rx_valid,
  output logic [7:0]  m_rx_data,
  input  logic        m_rx_ready,
  output logic        bus_cs,
  output logic        bus_we,
  output logic [7:0]  bus_addr,
  output logic [7:0]  bus_wdata,
  input  logic [7:0]  bus_rdata,
  output logic        busy
`ifdef UART_BUS_MASTER_STATS_EN
  ,
  output logic [15:0] tx_count,
  output logic [15:0] rx_count
`endif
);

  localparam int unsigned Depth      = 2 ** FIFO_AW;
  localparam logic [7:0]  AddrData   = 8'h00;
  localparam logic [7:0]  AddrStatus = 8'h01;

  typedef enum logic [2:0] {StIdle, StPoll, StRdData, StWrData, StGap} state_e;

  state_e             state_q;
  logic [7:0]         fifo_mem [Depth];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   count_q;
  logic [15:0]        holdoff_q;
  logic [15:0]        gap_q;
  logic               push, pop, fifo_empty;

  assign fifo_empty = (count_q == '0);
  assign s_tx_ready = (count_q != (FIFO_AW + 1)'(Depth));
  assign push       = s_tx_valid && s_tx_ready;
  assign pop        = (state_q == StWrData);
  assign busy       = !fifo_empty || (state_q == StRdData) || (state_q == StWrData);

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= s_tx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      bus_cs     <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= 8'h00;
      bus_wdata  <= 8'h00;
      m_rx_valid <= 1'b0;
      m_rx_data  <= 8'h00;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      holdoff_q  <= '0;
      gap_q      <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
      if (push && !pop)      count_q <= count_q + (FIFO_AW + 1)'(1);
      else if (pop && !push) count_q <= count_q - (FIFO_AW + 1)'(1);

      // Holdoff masks the stale TX-ready flag while the UART latches the byte.
      if (pop)                     holdoff_q <= 16'(WR_HOLDOFF);
      else if (holdoff_q != '0)    holdoff_q <= holdoff_q - 16'd1;

      if (state_q == StRdData) begin
        m_rx_valid <= 1'b1;
        m_rx_data  <= bus_rdata;
      end else if (m_rx_valid && m_rx_ready) begin
        m_rx_valid <= 1'b0;
      end

      // Unless a branch below overrides it, the next cycle is a STATUS poll.
      state_q  <= StPoll;
      bus_cs   <= 1'b1;
      bus_we   <= 1'b0;
      bus_addr <= AddrStatus;
      case (state_q)
        StPoll: begin
          if (bus_rdata[1] && !m_rx_valid) begin
            state_q  <= StRdData;
            bus_addr <= AddrData;
          end else if (bus_rdata[0] && (holdoff_q == '0) && !fifo_empty) begin
            state_q   <= StWrData;
            bus_we    <= 1'b1;
            bus_addr  <= AddrData;
            bus_wdata <= fifo_mem[rd_ptr_q];
          end else if (POLL_GAP > 0) begin
            state_q <= StGap;
            bus_cs  <= 1'b0;
            gap_q   <= 16'(POLL_GAP - 1);
          end
        end
        StGap: begin
          if (gap_q != '0) begin
            state_q <= StGap;
            bus_cs  <= 1'b0;
            gap_q   <= gap_q - 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef UART_BUS_MASTER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_count <= '0;
      rx_count <= '0;
    end else begin
      if ((state_q == StWrData) && (tx_count != 16'hFFFF)) tx_count <= tx_count + 16'd1;
      if ((state_q == StRdData) && (rx_count != 16'hFFFF)) rx_count <= rx_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_uart_bus_master.sv
// Self-checking bench for uart_bus_master: directed scenarios plus a randomized phase scored
// against a queue-based UART and byte-stream model.
`timescale 1ns / 1ps

module tb_uart_bus_master;

  localparam int unsigned FifoAw    = 2;
  localparam int unsigned PollGap   = 0;
  localparam int unsigned WrHoldoff = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       s_tx_valid;
  logic [7:0] s_tx_data;
  logic       s_tx_ready;
  logic       m_rx_valid;
  logic [7:0] m_rx_data;
  logic       m_rx_ready;
  logic       bus_cs, bus_we;
  logic [7:0] bus_addr, bus_wdata, bus_rdata;
  logic       busy;
`ifdef UART_BUS_MASTER_STATS_EN
  logic [15:0] tx_count, rx_count;
`endif

  // UART register model: STATUS = {rx available, tx ready}, DATA = head of the RX queue
  logic       tx_rdy, rx_avail;
  logic [7:0] rx_head;
  logic [7:0] uart_rx_q[$];
  assign bus_rdata = (bus_addr == 8'h01) ? {6'b0, rx_avail, tx_rdy} : rx_head;

  logic [7:0] tx_model_q[$];
  logic [7:0] rx_expect_q[$];
  int         wr_cyc_q[$];
  bit         acc_log[$];
  int         n_checks = 0, n_pass = 0;
  int         cyc = 0, wr_total = 0, rd_total = 0, hs_total = 0;
  int         last_wr_cyc = 0;
  bit         have_last_wr = 0;
  bit         mon_en = 0;
  bit         mon_rd;
  logic [7:0] mon_v;

  uart_bus_master #(
    .FIFO_AW   (FifoAw),
    .POLL_GAP  (PollGap),
    .WR_HOLDOFF(WrHoldoff)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_tx_valid(s_tx_valid),
    .s_tx_data (s_tx_data),
    .s_tx_ready(s_tx_ready),
    .m_rx_valid(m_rx_valid),
    .m_rx_data (m_rx_data),
    .m_rx_ready(m_rx_ready),
    .bus_cs    (bus_cs),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .busy      (busy)
`ifdef UART_BUS_MASTER_STATS_EN
    ,
    .tx_count  (tx_count),
    .rx_count  (rx_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, expv, $time);
  endtask

  task automatic refresh_rx();
    rx_avail = (uart_rx_q.size() != 0);
    rx_head  = rx_avail ? uart_rx_q[0] : 8'h00;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_byte(input logic [7:0] d);
    s_tx_valid = 1'b1;
    s_tx_data  = d;
    step(1);
    s_tx_valid = 1'b0;
  endtask

  task automatic clear_models();
    tx_model_q.delete();
    rx_expect_q.delete();
    uart_rx_q.delete();
    wr_cyc_q.delete();
    acc_log.delete();
    refresh_rx();
    have_last_wr = 0;
    wr_total = 0;
    rd_total = 0;
    hs_total = 0;
  endtask

  // Bus/stream monitor: samples mid-cycle, applies UART side effects just after the edge.
  always begin
    @(negedge clk);
    cyc++;
    mon_rd = 0;
    if (mon_en && rst_n) begin
      if (bus_cs && bus_we) begin
        check("wr_addr", bus_addr, 8'h00);
        if (tx_model_q.size() > 0) begin
          mon_v = tx_model_q.pop_front();
          check("wr_data", bus_wdata, mon_v);
        end else check("wr_unexpected", 1, 0);
        if (have_last_wr) check("wr_spacing", (cyc - last_wr_cyc) >= WrHoldoff + 2, 1);
        last_wr_cyc  = cyc;
        have_last_wr = 1;
        wr_total++;
        wr_cyc_q.push_back(cyc);
        acc_log.push_back(1'b1);
      end
      if (bus_cs && !bus_we && bus_addr == 8'h00) begin
        check("rd_while_valid", m_rx_valid, 0);
        if (uart_rx_q.size() == 0) check("rd_spurious", 1, 0);
        else begin
          rx_expect_q.push_back(rx_head);
          mon_rd = 1;
        end
        rd_total++;
        acc_log.push_back(1'b0);
      end
      if (m_rx_valid && m_rx_ready) begin
        if (rx_expect_q.size() > 0) begin
          mon_v = rx_expect_q.pop_front();
          check("rx_order", m_rx_data, mon_v);
        end else check("rx_unexpected", 1, 0);
        hs_total++;
      end
      if (s_tx_valid && s_tx_ready) tx_model_q.push_back(s_tx_data);
    end
    @(posedge clk);
    #1;
    if (mon_rd) begin
      mon_v = uart_rx_q.pop_front();
      refresh_rx();
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, k, p_cyc, b_hs;
    bit ok;
    logic r;
    rst_n      = 1'b0;
    s_tx_valid = 1'b0;
    s_tx_data  = 8'h00;
    m_rx_ready = 1'b0;
    tx_rdy     = 1'b1;
    refresh_rx();
    mon_en = 1;
    step(2);
    check("rst_cs", bus_cs, 0);
    check("rst_we", bus_we, 0);
    check("rst_addr", bus_addr, 8'h00);
    check("rst_wdata", bus_wdata, 8'h00);
    check("rst_rx_valid", m_rx_valid, 0);
    check("rst_rx_data", m_rx_data, 8'h00);
    check("rst_tx_ready", s_tx_ready, 1);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;

    // 1: idle polling with TX ready and nothing queued
    step(2);
    for (int i = 0; i < 3; i++) begin
      check("t1_poll", {bus_cs, bus_we, bus_addr}, {1'b1, 1'b0, 8'h01});
      check("t1_busy", busy, 0);
      step(1);
    end
    check("t1_no_access", wr_total + rd_total, 0);

    // 2: single writes, then holdoff spacing between consecutive writes
    base = wr_cyc_q.size();
    push_byte(8'h41);
    p_cyc = cyc;
    push_byte(8'h42);
    k = 0;
    while (wr_cyc_q.size() < base + 2 && k < 40) begin step(1); k++; end
    check("t2_two_writes", wr_cyc_q.size() >= base + 2, 1);
    if (wr_cyc_q.size() >= base + 2) begin
      check("t2_latency", (wr_cyc_q[base] - p_cyc) <= 3, 1);
      check("t2_holdoff_gap", wr_cyc_q[base+1] - wr_cyc_q[base], WrHoldoff + 2);
    end

    // 3: receive with consumer stalled, then drain
    tx_rdy = 1'b0;
    uart_rx_q.push_back(8'h5A);
    uart_rx_q.push_back(8'h77);
    refresh_rx();
    base = rd_total;
    b_hs = hs_total;
    k = 0;
    while (!m_rx_valid && k < 30) begin step(1); k++; end
    check("t3_rx_valid", m_rx_valid, 1);
    check("t3_rx_data", m_rx_data, 8'h5A);
    step(10);
    check("t3_rx_hold", {m_rx_valid, m_rx_data}, {1'b1, 8'h5A});
    check("t3_single_read", rd_total - base, 1);
    m_rx_ready = 1'b1;
    k = 0;
    while (hs_total < b_hs + 2 && k < 40) begin step(1); k++; end
    check("t3_drained", hs_total - b_hs, 2);
    check("t3_uart_empty", uart_rx_q.size(), 0);

    // 4: fill the FIFO while TX is not ready, overflow is refused
    base = wr_total;
    for (int i = 0; i < 5; i++) begin
      s_tx_valid = 1'b1;
      s_tx_data  = 8'h10 + 8'(i);
      @(negedge clk);
      r = s_tx_ready;
      step(1);
      check("t4_ready", r, (i < 4) ? 1 : 0);
    end
    s_tx_valid = 1'b0;
    check("t4_busy", busy, 1);
    step(3);
    check("t4_no_write", wr_total - base, 0);
    tx_rdy = 1'b1;
    step(50);
    check("t4_four_writes", wr_total - base, 4);
    check("t4_model_empty", tx_model_q.size(), 0);

    // 5: RX and TX both pending: read is issued first
    tx_rdy = 1'b0;
    push_byte(8'hE7);
    step(2);
    base = acc_log.size();
    uart_rx_q.push_back(8'hC3);
    refresh_rx();
    tx_rdy = 1'b1;
    k = 0;
    while (acc_log.size() < base + 2 && k < 30) begin step(1); k++; end
    check("t5_two_accesses", acc_log.size() >= base + 2, 1);
    if (acc_log.size() >= base + 2) check("t5_rx_first", acc_log[base], 1'b0);
    step(10);
`ifdef UART_BUS_MASTER_STATS_EN
    check("t5_tx_count", tx_count, wr_total);
    check("t5_rx_count", rx_count, rd_total);
`endif

    // 6: reset asserted in the middle of a DATA write
    tx_rdy = 1'b0;
    push_byte(8'hA1);
    push_byte(8'hA2);
    push_byte(8'hA3);
    tx_rdy = 1'b1;
    ok = 0;
    k = 0;
    while (!ok && k < 20) begin
      @(negedge clk);
      ok = bus_cs && bus_we;
      k++;
    end
    check("t6_saw_write", ok, 1);
    rst_n  = 1'b0;
    mon_en = 0;
    #1;
    check("t6_cs", bus_cs, 0);
    check("t6_we", bus_we, 0);
    check("t6_tx_ready", s_tx_ready, 1);
    check("t6_busy", busy, 0);
`ifdef UART_BUS_MASTER_STATS_EN
    check("t6_counts", {tx_count, rx_count}, 32'h0);
`endif
    step(1);
    rst_n = 1'b1;
    clear_models();
    mon_en = 1;
    step(12);
    check("t6_fifo_flushed", wr_total, 0);

    // Randomized traffic against the queue model
    for (int i = 0; i < 3000; i++) begin
      s_tx_valid = ($urandom_range(1) == 1);
      s_tx_data  = 8'($urandom);
      tx_rdy     = ($urandom_range(3) != 0);
      m_rx_ready = ($urandom_range(2) != 0);
      if ($urandom_range(15) == 0 && uart_rx_q.size() < 3) begin
        uart_rx_q.push_back(8'($urandom));
        refresh_rx();
      end
      step(1);
    end
    s_tx_valid = 1'b0;
    tx_rdy     = 1'b1;
    m_rx_ready = 1'b1;
    k = 0;
    while ((tx_model_q.size() || uart_rx_q.size() || rx_expect_q.size() || m_rx_valid)
           && k < 400) begin
      step(1);
      k++;
    end
    step(8);
    check("rnd_tx_drained", tx_model_q.size(), 0);
    check("rnd_rx_drained", rx_expect_q.size() + uart_rx_q.size(), 0);
    check("rnd_busy", busy, 0);
    check("rnd_reads_consumed", hs_total, rd_total);
`ifdef UART_BUS_MASTER_STATS_EN
    check("rnd_tx_count", tx_count, wr_total);
    check("rnd_rx_count", rx_count, rd_total);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
